// File: rtl/spi_adc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_adc_pkg : state encoding and beat-count helper for the SPI ADC RX  |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package spi_adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONVERT  = 3'd1,
    S_CS_SETUP = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_HOLD  = 3'd4
  } adc_state_t;

  // Beat count of the default 32-bit word over 4 lanes; parameterised
  // instances derive theirs through shift_beats().
  localparam int SHIFT_BEATS = 32 / 4;

  function automatic int shift_beats(input int data_width, input int num_sdi);
    return data_width / num_sdi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sck_gen : fabric SCK generator, counts BEATS pulses per burst      |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module spi_sck_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int BEATS     = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_sck,
  output logic                 o_rise,
  output logic                 o_last_fall
);

  localparam int PW = $clog2(BEATS + 1);

  logic                 r_active;
  logic                 r_sck;
  logic [DIV_WIDTH-1:0] r_half;
  logic [PW-1:0]        r_left;
  logic                 w_half_done;

  assign w_half_done = r_active && (r_half == '0);
  // The start strobe is itself the first rising edge.
  assign o_rise      = i_start || (w_half_done && !r_sck);
  assign o_last_fall = w_half_done && r_sck && (r_left == '0);
  assign o_sck       = r_sck;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_half   <= '0;
      r_left   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sck    <= 1'b1;
      r_half   <= i_div;
      r_left   <= PW'(BEATS - 1);
    end else if (w_half_done) begin
      r_sck  <= ~r_sck;
      r_half <= i_div;
      if (!r_sck)
        r_left <= r_left - 1'b1;
      if (o_last_fall)
        r_active <= 1'b0;
    end else if (r_active) begin
      r_half <= r_half - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_spi_adc_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_spi_adc_rx : triggered multi-lane SPI ADC reader, AXI-Stream out  |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module axis_spi_adc_rx
  import spi_adc_pkg::*;
#(
  parameter int NUM_SDI    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8,
  parameter int CNV_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  trigger,
  input  logic [DIV_WIDTH-1:0]  cfg_clk_div,
  input  logic [CNV_WIDTH-1:0]  cfg_cnv_cycles,
  input  logic                  overrun_clr,
  output logic                  spi_cnv,
  output logic                  spi_csn,
  output logic                  spi_sck,
  input  logic [NUM_SDI-1:0]    spi_sdi,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int BEATS = shift_beats(DATA_WIDTH, NUM_SDI);
  localparam int CW    = (CNV_WIDTH > DIV_WIDTH) ? CNV_WIDTH : DIV_WIDTH;

  adc_state_t            r_state, w_state_nxt;
  logic                  r_trig_d;
  logic                  w_trig_rise;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  w_sck_start;
  logic                  w_word_done;
  logic                  w_sck_rise;
  logic                  w_sck_last_fall;
  logic                  w_out_free;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_overrun;
  logic                  r_cnv;
  logic                  r_csn;
  logic                  r_busy;

  assign w_trig_rise = trigger && !r_trig_d;
  assign w_out_free  = !r_tvalid || m_axis_tready;

  spi_sck_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .BEATS     (BEATS)
  ) u_sck_gen (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_start     (w_sck_start),
    .i_div       (r_div),
    .o_sck       (spi_sck),
    .o_rise      (w_sck_rise),
    .o_last_fall (w_sck_last_fall)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_trig_d <= 1'b0;
      r_div    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_trig_d <= trigger;
      if (r_state == S_IDLE && w_trig_rise)
        r_div <= cfg_clk_div;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sck_start = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig_rise) begin
          w_state_nxt = S_CONVERT;
          // A wait setting of 0 still yields a single convert cycle.
          w_cnt_nxt   = (cfg_cnv_cycles == '0) ? '0 : CW'(cfg_cnv_cycles - 1'b1);
        end
      end
      S_CONVERT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_CS_SETUP;
          w_cnt_nxt   = CW'(r_div);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_CS_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SHIFT;
          w_sck_start = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_sck_last_fall) begin
          w_state_nxt = S_CS_HOLD;
          w_cnt_nxt   = CW'(r_div);
        end
      end
      S_CS_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_word_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin-level strobes are registered from the next state so they track
  // the FSM exactly and never glitch on a multi-bit state change.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnv  <= 1'b0;
      r_csn  <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_cnv  <= (w_state_nxt == S_CONVERT);
      r_csn  <= !(w_state_nxt == S_CS_SETUP || w_state_nxt == S_SHIFT ||
                  w_state_nxt == S_CS_HOLD);
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_shift   <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_sck_rise)
        r_shift <= (r_shift << NUM_SDI) | DATA_WIDTH'(spi_sdi);

      if (w_word_done && w_out_free) begin
        r_tdata  <= r_shift;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_word_done && !w_out_free)
        r_overrun <= 1'b1;
      else if (overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  assign spi_cnv       = r_cnv;
  assign spi_csn       = r_csn;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_axis_spi_adc_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_spi_adc_rx : directed bench, 4-lane/32b and 1-lane/16b DUTs    |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_axis_spi_adc_rx;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  cfg_clk_div = 8'd0;
  logic [15:0] cfg_cnv_cycles = 16'd1;
  logic        overrun_clr = 1'b0;
  logic        tready = 1'b1;

  logic        a_trig, a_cnv, a_csn, a_sck, a_tvalid, a_busy, a_overrun;
  logic [3:0]  a_sdi;
  logic [31:0] a_tdata;
  logic [31:0] a_word = 32'h0;
  int          a_idx = 0;

  logic        b_trig, b_cnv, b_csn, b_sck, b_tvalid, b_busy, b_overrun;
  logic [0:0]  b_sdi;
  logic [15:0] b_tdata;
  logic [15:0] b_word = 16'h0;
  int          b_idx = 0;

  logic        m_cnv, m_csn, m_sck, m_tvalid, m_busy, m_overrun;
  logic [31:0] m_tdata;

  int n_total = 0;
  int n_bad   = 0;

  int cnv_hi, pulses, csn_lows, run, setup_cyc, hold_cyc;
  int hi_min, hi_max, lo_min, lo_max;
  logic first_busy;
  logic [31:0] words[$];

  always #5 aclk = ~aclk;

  assign a_trig = trigger && !sel;
  assign b_trig = trigger && sel;

  axis_spi_adc_rx #(.NUM_SDI(4), .DATA_WIDTH(32), .DIV_WIDTH(8), .CNV_WIDTH(16)) u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .trigger(a_trig),
    .cfg_clk_div(cfg_clk_div), .cfg_cnv_cycles(cfg_cnv_cycles),
    .overrun_clr(overrun_clr), .spi_cnv(a_cnv), .spi_csn(a_csn),
    .spi_sck(a_sck), .spi_sdi(a_sdi), .m_axis_tdata(a_tdata),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .busy(a_busy), .overrun(a_overrun)
  );

  axis_spi_adc_rx #(.NUM_SDI(1), .DATA_WIDTH(16), .DIV_WIDTH(8), .CNV_WIDTH(16)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .trigger(b_trig),
    .cfg_clk_div(cfg_clk_div), .cfg_cnv_cycles(cfg_cnv_cycles),
    .overrun_clr(overrun_clr), .spi_cnv(b_cnv), .spi_csn(b_csn),
    .spi_sck(b_sck), .spi_sdi(b_sdi), .m_axis_tdata(b_tdata),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
    .busy(b_busy), .overrun(b_overrun)
  );

  // ADC models: present the next group after every SCK fall, restart on CSN high.
  always @(negedge a_sck or posedge a_csn) a_idx = a_csn ? 0 : a_idx + 1;
  always @(negedge b_sck or posedge b_csn) b_idx = b_csn ? 0 : b_idx + 1;
  assign a_sdi = (a_idx < 8)  ? a_word[31 - 4*a_idx -: 4] : 4'h0;
  assign b_sdi = (b_idx < 16) ? b_word[15 - b_idx]        : 1'b0;

  assign m_cnv     = sel ? b_cnv     : a_cnv;
  assign m_csn     = sel ? b_csn     : a_csn;
  assign m_sck     = sel ? b_sck     : a_sck;
  assign m_tvalid  = sel ? b_tvalid  : a_tvalid;
  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_overrun = sel ? b_overrun : a_overrun;
  assign m_tdata   = sel ? {16'h0, b_tdata} : a_tdata;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Runs one conversion on the selected DUT, sampling every cycle at negedge.
  task automatic observe(input bit do_trig, input int mid_trig_pulse, input int stop_pulse);
    logic prev_csn, prev_sck, seen_busy, done, mid_done;
    cnv_hi = 0; pulses = 0; csn_lows = 0; run = 0; setup_cyc = 0; hold_cyc = 0;
    hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
    words.delete();
    prev_csn = 1'b1; prev_sck = 1'b0; seen_busy = 1'b0; done = 1'b0; mid_done = 1'b0;
    trigger = do_trig;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge aclk);
      if (cyc == 0) first_busy = m_busy;
      if (m_cnv) cnv_hi++;
      if (!m_csn) begin
        if (prev_csn) begin
          csn_lows++;
          run = 1;
        end else if (m_sck != prev_sck) begin
          if (m_sck) begin
            pulses++;
            if (pulses == 1) setup_cyc = run;
            else begin
              if (run < lo_min) lo_min = run;
              if (run > lo_max) lo_max = run;
            end
          end else begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
          end
          run = 1;
        end else begin
          run++;
        end
      end else if (!prev_csn) begin
        hold_cyc = run;
      end
      prev_csn = m_csn;
      prev_sck = m_sck;
      if (m_tvalid && tready) words.push_back(m_tdata);
      if (m_busy) seen_busy = 1'b1;
      trigger = 1'b0;
      if (mid_trig_pulse >= 0 && pulses == mid_trig_pulse && !mid_done) begin
        trigger  = 1'b1;
        mid_done = 1'b1;
      end
      if (stop_pulse > 0 && pulses == stop_pulse) begin done = 1'b1; break; end
      if (seen_busy && !m_busy) begin done = 1'b1; break; end
    end
    trigger = 1'b0;
    check_eq("observe_done", done, 1);
  endtask

  initial begin
    int stray_valid, stray_busy;
    logic [31:0] w1;

    // Reset state
    repeat (3) @(negedge aclk);
    check_eq("rst_csn", a_csn, 1);
    check_eq("rst_cnv", a_cnv, 0);
    check_eq("rst_sck", a_sck, 0);
    check_eq("rst_tvalid", a_tvalid, 0);
    check_eq("rst_tdata", a_tdata, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_overrun", a_overrun, 0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // 4 lanes, div 0, cnv 3
    sel = 1'b0; cfg_clk_div = 8'd0; cfg_cnv_cycles = 16'd3; tready = 1'b1;
    a_word = 32'hDEADBEEF;
    observe(1'b1, -1, 0);
    check_eq("a_cnv_cycles", cnv_hi, 3);
    check_eq("a_pulses", pulses, 8);
    check_eq("a_sck_hi", {hi_min[15:0], hi_max[15:0]}, {16'd1, 16'd1});
    check_eq("a_sck_lo", {lo_min[15:0], lo_max[15:0]}, {16'd1, 16'd1});
    check_eq("a_cs_setup", setup_cyc, 1);
    check_eq("a_cs_hold", hold_cyc, 1);
    check_eq("a_tvalid", m_tvalid, 1);
    check_eq("a_overrun", m_overrun, 0);
    check_eq("a_words", words.size(), 1);
    check_eq("a_tdata", (words.size() > 0) ? words[0] : 32'hX, 32'hDEADBEEF);

    // 1 lane, 16 bits, div 2
    @(negedge aclk);
    sel = 1'b1; cfg_clk_div = 8'd2; cfg_cnv_cycles = 16'd1;
    b_word = 16'hA5C3;
    observe(1'b1, -1, 0);
    check_eq("b_cnv_cycles", cnv_hi, 1);
    check_eq("b_pulses", pulses, 16);
    check_eq("b_sck_hi", {hi_min[15:0], hi_max[15:0]}, {16'd3, 16'd3});
    check_eq("b_sck_lo", {lo_min[15:0], lo_max[15:0]}, {16'd3, 16'd3});
    check_eq("b_cs_setup", setup_cyc, 3);
    check_eq("b_cs_hold", hold_cyc, 3);
    check_eq("b_tdata", (words.size() > 0) ? words[0] : 32'hX, 32'h0000A5C3);

    // Backpressure: second word dropped, overrun sticky until cleared
    @(negedge aclk);
    sel = 1'b0; cfg_clk_div = 8'd0; cfg_cnv_cycles = 16'd2; tready = 1'b0;
    a_word = 32'h12345678;
    observe(1'b1, -1, 0);
    check_eq("bp1_tvalid", m_tvalid, 1);
    check_eq("bp1_tdata", m_tdata, 32'h12345678);
    check_eq("bp1_overrun", m_overrun, 0);
    @(negedge aclk);
    a_word = 32'hCAFEF00D;
    observe(1'b1, -1, 0);
    check_eq("bp2_tvalid", m_tvalid, 1);
    check_eq("bp2_tdata", m_tdata, 32'h12345678);
    check_eq("bp2_overrun", m_overrun, 1);
    overrun_clr = 1'b1;
    @(negedge aclk);
    overrun_clr = 1'b0;
    check_eq("clr_overrun", m_overrun, 0);
    check_eq("clr_tdata", m_tdata, 32'h12345678);
    tready = 1'b1;
    @(negedge aclk);
    check_eq("drain_tvalid", m_tvalid, 0);

    // Trigger edge during SHIFT is ignored
    cfg_clk_div = 8'd1; cfg_cnv_cycles = 16'd2;
    a_word = 32'h0F1E2D3C;
    observe(1'b1, 3, 0);
    check_eq("mid_csn_lows", csn_lows, 1);
    check_eq("mid_words", words.size(), 1);
    check_eq("mid_tdata", (words.size() > 0) ? words[0] : 32'hX, 32'h0F1E2D3C);
    stray_busy = 0;
    repeat (30) begin
      @(negedge aclk);
      if (m_busy) stray_busy++;
    end
    check_eq("mid_no_requeue", stray_busy, 0);

    // Reset at the 4th SCK pulse
    cfg_clk_div = 8'd0; cfg_cnv_cycles = 16'd1;
    a_word = 32'h89ABCDEF;
    observe(1'b1, -1, 4);
    check_eq("abort_reached", pulses, 4);
    aresetn = 1'b0;
    #1;
    check_eq("abort_csn", a_csn, 1);
    check_eq("abort_sck", a_sck, 0);
    check_eq("abort_cnv", a_cnv, 0);
    check_eq("abort_busy", a_busy, 0);
    check_eq("abort_tvalid", a_tvalid, 0);
    check_eq("abort_tdata", a_tdata, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    stray_valid = 0; stray_busy = 0;
    repeat (40) begin
      @(negedge aclk);
      if (a_tvalid) stray_valid++;
      if (a_busy) stray_busy++;
    end
    check_eq("abort_no_tvalid", stray_valid, 0);
    check_eq("abort_no_busy", stray_busy, 0);

    // Back-to-back: trigger on the first IDLE cycle
    cfg_clk_div = 8'd0; cfg_cnv_cycles = 16'd1; tready = 1'b1;
    a_word = 32'h11223344;
    observe(1'b1, -1, 0);
    w1 = (words.size() > 0) ? words[0] : 32'hX;
    a_word = 32'h55667788;
    observe(1'b1, -1, 0);
    check_eq("b2b_restart_busy", first_busy, 1);
    check_eq("b2b_word1", w1, 32'h11223344);
    check_eq("b2b_word2", (words.size() > 0) ? words[0] : 32'hX, 32'h55667788);
    check_eq("b2b_pulses", pulses, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_spi_adc_rx.md
AXIS_SPI_ADC_RX -- requirements
Module: axis_spi_adc_rx

Interface
REQ-001 SHALL have parameter NUM_SDI, default 4, number of parallel SDI lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per conversion word; a multiple of NUM_SDI.
REQ-003 SHALL have parameter DIV_WIDTH, default 8, width of the SCK divider setting.
REQ-004 SHALL have parameter CNV_WIDTH, default 16, width of the conversion-wait setting.
REQ-005 SHALL have ports, clock and reset first:
- aclk  in  1  system clock.
- aresetn  in  1  reset, asynchronous, active-low; clock aclk.
- trigger  in  1  conversion request, rising-edge detected.
- cfg_clk_div  in  DIV_WIDTH  SCK half-period minus 1, in aclk cycles.
- cfg_cnv_cycles  in  CNV_WIDTH  conversion wait in aclk cycles; 0 means 1.
- overrun_clr  in  1  clears the overrun flag.
- spi_cnv  out  1  ADC convert-start pulse.
- spi_csn  out  1  chip select, active-low.
- spi_sck  out  1  SPI clock, fabric-generated, idle low.
- spi_sdi  in  NUM_SDI  ADC data lanes.
- m_axis_tdata  out  DATA_WIDTH  conversion word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: a word was dropped.

Function
REQ-006 SHALL implement the FSM IDLE -> CONVERT -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
REQ-007 SHALL leave IDLE only on a trigger rising edge (trigger high, previous-cycle trigger low), latching cfg_clk_div and cfg_cnv_cycles at that edge.
REQ-008 SHALL ignore trigger edges outside IDLE, with no queuing.
REQ-009 SHALL hold spi_cnv high for exactly max(cfg_cnv_cycles,1) cycles in CONVERT, then enter CS_SETUP.
REQ-010 SHALL drive spi_csn low for one half-period (cfg_clk_div+1 cycles) in CS_SETUP before the first SCK rise.
REQ-011 SHALL emit exactly DATA_WIDTH/NUM_SDI SCK pulses in SHIFT, each high and each low for cfg_clk_div+1 cycles; a divider of 0 gives SCK = aclk/2.
REQ-012 SHALL sample spi_sdi on the aclk edge that drives spi_sck low-to-high, then shift the word left by NUM_SDI with spi_sdi in the LSBs (MSB-first; lane NUM_SDI-1 most significant within each group).
REQ-013 SHALL, after the last SCK falling edge, hold spi_csn low for one half-period in CS_HOLD, then raise spi_csn and return to IDLE.
REQ-014 SHALL present the completed word on the cycle after CS_HOLD exit: m_axis_tvalid=1 and m_axis_tdata=word, provided the output register is empty or being accepted in that cycle.
REQ-015 SHALL, if the output register holds an unaccepted word at completion, drop the new word, keep tdata stable and set overrun.
REQ-016 SHALL keep m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 SHALL clear m_axis_tvalid on a cycle with tvalid&&tready unless a new word loads in the same cycle, in which case tvalid stays 1 with the new data.
REQ-018 SHALL clear overrun on overrun_clr; a simultaneous set wins.
REQ-019 SHALL allow back-to-back conversions: a trigger edge on the first IDLE cycle is accepted.

Reset
REQ-020 SHALL, on aresetn low, asynchronously enter IDLE with: spi_csn=1, spi_cnv=0, spi_sck=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, overrun=0, and all counters and the trigger history cleared.
REQ-021 SHALL abort a transfer in progress on reset mid-operation, with no partial word emitted after release.

Structure
REQ-022 SHALL place the FSM state encoding and the derived constant SHIFT_BEATS=DATA_WIDTH/NUM_SDI in the shared package spi_adc_pkg.
REQ-023 SHALL implement SCK generation (half-period counter, edge strobes, pulse counter) as one sub-module, spi_sck_gen.

Verification
REQ-024 SHALL be checked with NUM_SDI=4, DATA_WIDTH=32, div=0, cnv=3, a trigger, and an ADC model driving 0xDEADBEEF: spi_cnv high 3 cycles, 8 SCK pulses, tdata=0xDEADBEEF, tvalid=1, overrun=0.
REQ-025 SHALL be checked with NUM_SDI=1, DATA_WIDTH=16, div=2: 16 pulses, each high 3 and low 3 cycles, and the word 0xA5C3 captured.
REQ-026 SHALL be checked with tready held 0 across two conversions: the first word stays on tdata, overrun=1, and overrun_clr then returns overrun to 0.
REQ-027 SHALL be checked with a trigger edge during SHIFT: it is ignored, and exactly one word and one csn low period result.
REQ-028 SHALL be checked with aresetn asserted at the 4th SCK pulse: outputs take reset values immediately and no tvalid follows release.
REQ-029 SHALL be checked with tready=1 and a trigger on the first IDLE cycle after completion: a second conversion starts immediately, and both words are delivered in order.
